// File: rtl/tracker_mode_arbiter.sv
// N-way tracker source arbiter: keyboard mode switching on frame boundaries, blank frame, lost filter.
// Optional SHOOT_STRETCH_EN holds shoot until the second frame boundary after it fires.
module tracker_mode_arbiter #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned DEFAULT_SRC = 0,
    parameter int unsigned LOST_FRAMES = 8,
    parameter int unsigned CENTER_X    = 320,
    parameter int unsigned CENTER_Y    = 240
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       v_sync,
    input  logic                       key_valid,
    input  logic [7:0]                 key_data,
    input  logic [NUM_SRC*COLOR_W-1:0] src_r,
    input  logic [NUM_SRC*COLOR_W-1:0] src_g,
    input  logic [NUM_SRC*COLOR_W-1:0] src_b,
    input  logic [NUM_SRC*COORD_W-1:0] src_x,
    input  logic [NUM_SRC*COORD_W-1:0] src_y,
    input  logic [NUM_SRC-1:0]         src_detect,
    input  logic [NUM_SRC-1:0]         src_shoot,
    input  logic [NUM_SRC-1:0]         src_target_off,
    output logic [COLOR_W-1:0]         r_port,
    output logic [COLOR_W-1:0]         g_port,
    output logic [COLOR_W-1:0]         b_port,
    output logic [COORD_W-1:0]         x_coor,
    output logic [COORD_W-1:0]         y_coor,
    output logic                       red_detect,
    output logic                       shoot,
    output logic                       target_off,
    output logic [1:0]                 mode_sel,
    output logic                       switching
);

    typedef enum logic [1:0] {StActive, StPending, StBlank} state_e;

    localparam logic [7:0]         LostMax    = 8'(LOST_FRAMES);
    localparam logic [1:0]         DefaultSrc = 2'(DEFAULT_SRC);
    localparam logic [COORD_W-1:0] CenterX    = COORD_W'(CENTER_X);
    localparam logic [COORD_W-1:0] CenterY    = COORD_W'(CENTER_Y);

    state_e       state_q, state_d;
    logic [1:0]   mode_q, mode_d, pend_q, pend_d;
    logic [7:0]   lost_cnt_q, lost_cnt_d;
    logic         v_sync_q;
    logic         fb, lost;
    logic [1:0]   req_idx;
    logic         req_hit, req_valid;

    logic [COLOR_W-1:0] sel_r, sel_g, sel_b;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic               sel_detect, sel_shoot, sel_off;

    logic [COORD_W-1:0] x_d, y_d;
    logic               det_d, shoot_raw, shoot_d, off_d;

    assign fb   = v_sync_q & ~v_sync;
    assign lost = (lost_cnt_q == LostMax);

    always_comb begin
        req_idx = 2'd0;
        req_hit = 1'b0;
        case (key_data)
            8'h16: begin req_idx = 2'd0; req_hit = 1'b1; end
            8'h1E: begin req_idx = 2'd1; req_hit = 1'b1; end
            8'h26: begin req_idx = 2'd2; req_hit = 1'b1; end
            8'h25: begin req_idx = 2'd3; req_hit = 1'b1; end
            default: ;
        endcase
        req_valid = key_valid & req_hit & ({30'd0, req_idx} < NUM_SRC);
    end

    always_comb begin
        sel_r      = '0;
        sel_g      = '0;
        sel_b      = '0;
        sel_x      = '0;
        sel_y      = '0;
        sel_detect = 1'b0;
        sel_shoot  = 1'b0;
        sel_off    = 1'b1;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (mode_q == 2'(i)) begin
                sel_r      = src_r[i*COLOR_W +: COLOR_W];
                sel_g      = src_g[i*COLOR_W +: COLOR_W];
                sel_b      = src_b[i*COLOR_W +: COLOR_W];
                sel_x      = src_x[i*COORD_W +: COORD_W];
                sel_y      = src_y[i*COORD_W +: COORD_W];
                sel_detect = src_detect[i];
                sel_shoot  = src_shoot[i];
                sel_off    = src_target_off[i];
            end
        end
    end

    // A key arriving together with fb is applied before the fb decision.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pend_d     = pend_q;
        lost_cnt_d = lost_cnt_q;
        unique case (state_q)
            StActive: begin
                if (fb) begin
                    if (sel_detect)  lost_cnt_d = '0;
                    else if (!lost)  lost_cnt_d = lost_cnt_q + 8'd1;
                end
                if (req_valid && req_idx != mode_q) begin
                    pend_d  = req_idx;
                    state_d = StPending;
                end
            end
            StPending: begin
                if (req_valid && req_idx == mode_q) begin
                    state_d = StActive;
                end else begin
                    if (req_valid) pend_d = req_idx;
                    if (fb) begin
                        mode_d     = pend_d;
                        lost_cnt_d = '0;
                        state_d    = StBlank;
                    end
                end
            end
            StBlank: begin
                if (req_valid) pend_d = req_idx;
                if (fb) state_d = (pend_d != mode_q) ? StPending : StActive;
            end
            default: state_d = StActive;
        endcase
    end

    always_comb begin
        x_d       = sel_x;
        y_d       = sel_y;
        det_d     = sel_detect;
        shoot_raw = sel_shoot & sel_detect;
        off_d     = sel_off;
        if (state_q == StBlank) begin
            x_d       = CenterX;
            y_d       = CenterY;
            det_d     = 1'b0;
            shoot_raw = 1'b0;
            off_d     = 1'b1;
        end else if (lost) begin
            x_d       = CenterX;
            y_d       = CenterY;
            det_d     = 1'b0;
            shoot_raw = 1'b0;
        end
    end

`ifdef SHOOT_STRETCH_EN
    logic stretch_q, stretch_d, stretch_fb_q, stretch_fb_d;

    // stretch_fb_q marks that the first fb after the set has already passed.
    always_comb begin
        stretch_d    = stretch_q;
        stretch_fb_d = stretch_fb_q;
        if (state_d == StBlank && state_q != StBlank) begin
            stretch_d    = 1'b0;
            stretch_fb_d = 1'b0;
        end else if (state_q == StActive && shoot_raw) begin
            stretch_d    = 1'b1;
            stretch_fb_d = 1'b0;
        end else if (stretch_q && fb) begin
            if (stretch_fb_q) stretch_d = 1'b0;
            stretch_fb_d = ~stretch_fb_q;
        end
        shoot_d = shoot_raw | stretch_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stretch_q    <= 1'b0;
            stretch_fb_q <= 1'b0;
        end else begin
            stretch_q    <= stretch_d;
            stretch_fb_q <= stretch_fb_d;
        end
    end
`else
    assign shoot_d = shoot_raw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StActive;
            mode_q     <= DefaultSrc;
            pend_q     <= DefaultSrc;
            lost_cnt_q <= '0;
            v_sync_q   <= 1'b1;
            x_coor     <= CenterX;
            y_coor     <= CenterY;
            red_detect <= 1'b0;
            shoot      <= 1'b0;
            target_off <= 1'b1;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            lost_cnt_q <= lost_cnt_d;
            v_sync_q   <= v_sync;
            x_coor     <= x_d;
            y_coor     <= y_d;
            red_detect <= det_d;
            shoot      <= shoot_d;
            target_off <= off_d;
        end
    end

    assign r_port    = (state_q == StBlank) ? '0 : sel_r;
    assign g_port    = (state_q == StBlank) ? '0 : sel_g;
    assign b_port    = (state_q == StBlank) ? '0 : sel_b;
    assign mode_sel  = mode_q;
    assign switching = (state_q != StActive);

endmodule

// File: tb/tb_tracker_mode_arbiter.sv
// Randomized scoreboard bench for tracker_mode_arbiter (3 sources, LOST_FRAMES=3).
module tb_tracker_mode_arbiter;

    localparam int NS = 3;
    localparam int CW = 10;
    localparam int KW = 4;
    localparam int LF = 3;
    localparam int DEF = 0;
    localparam int CX = 320;
    localparam int CY = 240;
    localparam int CYCLES = 4000;

    logic clk = 1'b0;
    logic reset, v_sync, key_valid;
    logic [7:0] key_data;
    logic [NS*KW-1:0] src_r, src_g, src_b;
    logic [NS*CW-1:0] src_x, src_y;
    logic [NS-1:0] src_detect, src_shoot, src_target_off;
    logic [KW-1:0] r_port, g_port, b_port;
    logic [CW-1:0] x_coor, y_coor;
    logic red_detect, shoot, target_off, switching;
    logic [1:0] mode_sel;

    always #5 clk = ~clk;

    tracker_mode_arbiter #(
        .NUM_SRC(NS), .COORD_W(CW), .COLOR_W(KW), .DEFAULT_SRC(DEF),
        .LOST_FRAMES(LF), .CENTER_X(CX), .CENTER_Y(CY)
    ) dut (
        .clk(clk), .reset(reset), .v_sync(v_sync), .key_valid(key_valid), .key_data(key_data),
        .src_r(src_r), .src_g(src_g), .src_b(src_b), .src_x(src_x), .src_y(src_y),
        .src_detect(src_detect), .src_shoot(src_shoot), .src_target_off(src_target_off),
        .r_port(r_port), .g_port(g_port), .b_port(b_port), .x_coor(x_coor), .y_coor(y_coor),
        .red_detect(red_detect), .shoot(shoot), .target_off(target_off),
        .mode_sel(mode_sel), .switching(switching)
    );

    typedef struct {
        int r, g, b, x, y, det, sht, off, mode, sw;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    // Model state: phase 0 = showing a source, 1 = waiting for frame end, 2 = blank frame.
    int  m_phase = 0;
    int  m_mode = DEF;
    int  m_pend = DEF;
    int  m_misses = 0;
    bit  m_vs_prev = 1'b1;

    function automatic int decode(input logic kv, input logic [7:0] k);
        int idx;
        if (!kv) return -1;
        case (k)
            8'h16: idx = 0;
            8'h1E: idx = 1;
            8'h26: idx = 2;
            8'h25: idx = 3;
            default: idx = -1;
        endcase
        return (idx < NS) ? idx : -1;
    endfunction

    task automatic model_step(output exp_t e);
        bit fb, is_lost;
        int req, sx, sy, sdet, ssht, soff;
        sx   = int'(src_x[m_mode*CW +: CW]);
        sy   = int'(src_y[m_mode*CW +: CW]);
        sdet = int'(src_detect[m_mode]);
        ssht = int'(src_shoot[m_mode]);
        soff = int'(src_target_off[m_mode]);
        if (reset) begin
            e.x = CX; e.y = CY; e.det = 0; e.sht = 0; e.off = 1;
            m_phase = 0; m_mode = DEF; m_pend = DEF; m_misses = 0; m_vs_prev = 1'b1;
        end else begin
            fb = m_vs_prev && !v_sync;
            is_lost = (m_misses == LF);
            if (m_phase == 2) begin
                e.x = CX; e.y = CY; e.det = 0; e.sht = 0; e.off = 1;
            end else if (is_lost) begin
                e.x = CX; e.y = CY; e.det = 0; e.sht = 0; e.off = soff;
            end else begin
                e.x = sx; e.y = sy; e.det = sdet; e.sht = ssht & sdet; e.off = soff;
            end
            req = decode(key_valid, key_data);
            if (m_phase == 0) begin
                if (fb) m_misses = sdet ? 0 : ((m_misses < LF) ? m_misses + 1 : LF);
                if (req >= 0 && req != m_mode) begin
                    m_pend = req;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (req >= 0 && req == m_mode) begin
                    m_phase = 0;
                end else begin
                    if (req >= 0) m_pend = req;
                    if (fb) begin
                        m_mode = m_pend;
                        m_misses = 0;
                        m_phase = 2;
                    end
                end
            end else begin
                if (req >= 0) m_pend = req;
                if (fb) m_phase = (m_pend != m_mode) ? 1 : 0;
            end
            m_vs_prev = v_sync;
        end
        e.mode = m_mode;
        e.sw = (m_phase != 0) ? 1 : 0;
        e.r = (m_phase == 2) ? 0 : int'(src_r[m_mode*KW +: KW]);
        e.g = (m_phase == 2) ? 0 : int'(src_g[m_mode*KW +: KW]);
        e.b = (m_phase == 2) ? 0 : int'(src_b[m_mode*KW +: KW]);
    endtask

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
        end
    endtask

    // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mode_sel", int'(mode_sel), e.mode);
                chk("switching", int'(switching), e.sw);
                chk("r_port", int'(r_port), e.r);
                chk("g_port", int'(g_port), e.g);
                chk("b_port", int'(b_port), e.b);
                chk("x_coor", int'(x_coor), e.x);
                chk("y_coor", int'(y_coor), e.y);
                chk("red_detect", int'(red_detect), e.det);
                chk("shoot", int'(shoot), e.sht);
                chk("target_off", int'(target_off), e.off);
            end
        end
    end

    initial begin
        exp_t e;
        int vs_left = 4;
        logic [7:0] codes [4];
        codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h26; codes[3] = 8'h25;
        reset = 1'b1; v_sync = 1'b1; key_valid = 1'b0; key_data = 8'h00;
        src_r = '0; src_g = '0; src_b = '0; src_x = '0; src_y = '0;
        src_detect = '0; src_shoot = '0; src_target_off = '1;
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            reset = (cyc < 3) || ($urandom_range(0, 499) == 0);
            if (vs_left == 0) begin
                v_sync = ~v_sync;
                vs_left = v_sync ? $urandom_range(6, 18) : $urandom_range(0, 2);
            end else begin
                vs_left--;
            end
            key_valid = ($urandom_range(0, 9) == 0);
            key_data = ($urandom_range(0, 4) != 0) ? codes[$urandom_range(0, 3)] : 8'($urandom);
            src_r = (NS*KW)'($urandom);
            src_g = (NS*KW)'($urandom);
            src_b = (NS*KW)'($urandom);
            src_x = (NS*CW)'({$urandom, $urandom});
            src_y = (NS*CW)'({$urandom, $urandom});
            for (int i = 0; i < NS; i++) begin
                src_detect[i] = ($urandom_range(0, 9) < 3);
                src_shoot[i] = $urandom_range(0, 1) == 1;
                src_target_off[i] = $urandom_range(0, 1) == 1;
            end
            #1;
            model_step(e);
            exp_q.push_back(e);
        end
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
